// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types, constants and baud helper (used by uart_tx/rx)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 receiver with one-deep valid/ready holding register.
// Optional: UART_RX_MAJORITY_EN (2-of-3 majority vote at every sample point).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_CLK_HZ = 27000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      rx_pin,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_data_valid,
  input  logic                      rx_data_ready,
  output logic                      rx_frame_error,
  output logic                      rx_overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(UART_CLK_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic                      sync1_q;
  logic                      rx_s_q;
  logic                      w_sample;
  uart_rx_state_t            state_q;
  logic [CNT_W-1:0]          clk_cnt_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      rx_s_q  <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign w_sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign w_sample = rx_s_q;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (clk_cnt_q == C_CNT_HALF) begin
            clk_cnt_q <= '0;
            if (w_sample) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == C_CNT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= w_sample;
            if (bit_idx_q == C_IDX_LAST) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
          if (clk_cnt_q == C_CNT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (!w_sample) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || rx_data_ready) begin
              rx_data_q <= shift_q;
              valid_q   <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_data_valid  = valid_q;
  assign rx_frame_error = frame_err_q;
  assign rx_overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed, table-driven bench for uart_rx at default parameters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 234;
  localparam int HALF = 117;
  localparam int LAT = 2226;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_error;
  logic       rx_overrun;

  uart_rx dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_frame_error(rx_frame_error),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses, valid rises and accepted bytes.
  always @(negedge clk) begin
    if (rx_frame_error) fe_cnt <= fe_cnt + 1;
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
    if (rx_frame_error && rx_overrun) both_cnt <= both_cnt + 1;
    if (rx_data_valid && !prev_valid) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_valid <= rx_data_valid;
    if (rx_data_valid && rx_data_ready) acc_q.push_back(rx_data);
  end

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         n_acc;
    int         n_fe;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 10-bit frame, one line value per clock. Optional one-cycle
  // glitches at each data sample point, a ready pulse and a reset assertion.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit glitch,
                            input int ready_c, input int rst_c, output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0 = 0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) t0 = cyc;
      rx_pin = bits[c / CPB];
      if (glitch && c >= HALF + CPB && c <= HALF + 8 * CPB && ((c - HALF) % CPB) == 0)
        rx_pin = ~bits[c / CPB];
      if (ready_c >= 0 && c == ready_c) rx_data_ready = 1'b1;
      if (ready_c >= 0 && c == ready_c + 1) rx_data_ready = 1'b0;
      if (rst_c >= 0 && c == rst_c) n_reset = 1'b0;
    end
    if (!stop) begin
      @(posedge clk);
      #1;
      rx_pin = 1'b1;
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  initial begin
    int t0;
    int fe0, ov0, rise0, acc0;

    tbl[0] = '{data: 8'h3C, stop: 1'b1, n_acc: 1, n_fe: 0};
    tbl[1] = '{data: 8'h55, stop: 1'b0, n_acc: 0, n_fe: 1};
    tbl[2] = '{data: 8'h01, stop: 1'b1, n_acc: 1, n_fe: 0};
    tbl[3] = '{data: 8'hC3, stop: 1'b1, n_acc: 1, n_fe: 0};
    tbl[4] = '{data: 8'h80, stop: 1'b1, n_acc: 1, n_fe: 0};

    // Reset state
    idle(5);
    @(negedge clk);
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_data_valid, 1'b0);
    check("reset_fe", rx_frame_error, 1'b0);
    check("reset_ov", rx_overrun, 1'b0);
    n_reset = 1'b1;
    idle(10);

    // 0xA5 latency and hold-until-consumed
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, t0);
    idle(20);
    check("lat_cycles", rise_cyc - t0, LAT);
    check("lat_data", rx_data, 8'hA5);
    check("lat_hold_valid", rx_data_valid, 1'b1);
    pulse_ready();
    @(negedge clk);
    check("consume_valid", rx_data_valid, 1'b0);
    check("consume_data_hold", rx_data, 8'hA5);
    idle(5);

    // 50-cycle glitch on an idle line
    rx_data_ready = 1'b1;
    fe0 = fe_cnt; rise0 = rise_cnt;
    rx_pin = 1'b0;
    idle(50);
    rx_pin = 1'b1;
    idle(300);
    check("glitch_no_valid", rise_cnt - rise0, 0);
    check("glitch_no_fe", fe_cnt - fe0, 0);

    // Table of single frames, ready tied high
    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_q.size();
      send_frame(tbl[i].data, tbl[i].stop, 1'b0, -1, -1, t0);
      idle(20);
      check($sformatf("tbl%0d_nacc", i), acc_q.size() - acc0, tbl[i].n_acc);
      check($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].n_fe);
      check($sformatf("tbl%0d_ov", i), ov_cnt - ov0, 0);
      check($sformatf("tbl%0d_valid", i), rx_data_valid, 1'b0);
      if (tbl[i].n_acc == 1 && acc_q.size() > acc0)
        check($sformatf("tbl%0d_data", i), acc_q[acc0], tbl[i].data);
    end

    // Back-to-back 0x00, 0xFF with no idle gap
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_q.size();
    send_frame(8'h00, 1'b1, 1'b0, -1, -1, t0);
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1, t0);
    idle(20);
    check("b2b_count", acc_q.size() - acc0, 2);
    if (acc_q.size() >= acc0 + 2) begin
      check("b2b_first", acc_q[acc0], 8'h00);
      check("b2b_second", acc_q[acc0 + 1], 8'hFF);
    end
    check("b2b_fe", fe_cnt - fe0, 0);
    check("b2b_ov", ov_cnt - ov0, 0);

    // Overrun: second byte dropped while the first is unread
    rx_data_ready = 1'b0;
    idle(5);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, -1, t0);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1, t0);
    idle(20);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_keep_data", rx_data, 8'h11);
    check("ovr_valid", rx_data_valid, 1'b1);
    check("ovr_no_fe", fe_cnt - fe0, 0);
    pulse_ready();
    idle(5);

    // Consume in the completion cycle: no overrun, new byte loaded
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, -1, t0);
    send_frame(8'h22, 1'b1, 1'b0, LAT - 1, -1, t0);
    idle(20);
    check("same_cycle_ov", ov_cnt - ov0, 0);
    check("same_cycle_data", rx_data, 8'h22);
    check("same_cycle_valid", rx_data_valid, 1'b1);
    pulse_ready();
    idle(5);

    // Reset mid data bit 4 of 0x81, then a clean 0x7E
    rx_data_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
    send_frame(8'h81, 1'b1, 1'b0, -1, 5 * CPB + HALF, t0);
    @(negedge clk);
    check("rst_mid_data", rx_data, 8'h00);
    check("rst_mid_valid", rx_data_valid, 1'b0);
    idle(1);
    n_reset = 1'b1;
    idle(20);
    check("rst_mid_no_valid", rise_cnt - rise0, 0);
    check("rst_mid_no_fe", fe_cnt - fe0, 0);
    check("rst_mid_no_ov", ov_cnt - ov0, 0);
    acc0 = acc_q.size();
    send_frame(8'h7E, 1'b1, 1'b0, -1, -1, t0);
    idle(20);
    check("post_rst_count", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("post_rst_data", acc_q[acc0], 8'h7E);

`ifdef UART_RX_MAJORITY_EN
    acc0 = acc_q.size();
    send_frame(8'h7E, 1'b1, 1'b1, -1, -1, t0);
    idle(20);
    check("maj_count", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("maj_data", acc_q[acc0], 8'h7E);
`endif

    check("fe_ov_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
